apb_protocol_monitor: RTL and testbench

Synthesizable, parametrised APB4 protocol monitor that passively observes one slave port and reports protocol violations as sticky flags, a per-event pulse, and saturating transfer/error counters. It is the hardware successor to our simulation-only APB assertions: the same reset, read, write and strobe rules, plus wait-state timeout, stability, abort and address-map checks, usable on silicon and in emulation. It sits beside the APB slave, tapping the bus without driving it.

---
 rtl/apb_protocol_monitor.sv | 174 +++++++++++++++++
 tb/tb_apb_protocol_monitor.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/apb_protocol_monitor.sv
// Passive APB4 protocol monitor: classifies each bus sample, raises sticky violation
// flags and a one-cycle pulse, and keeps saturating transfer and error counters.
module apb_protocol_monitor #(
  parameter int unsigned ADDR_W     = 16,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned BASE_ADDR  = 32'h0000,
  parameter int unsigned NUM_REGS   = 16,
  parameter int unsigned REG_STRIDE = 32'h0040,
  parameter int unsigned TIMEOUT    = 3,
  parameter int unsigned CNT_W      = 8
) (
  input  logic                pclk_i,
  input  logic                preset_i,
  input  logic                pselx_i,
  input  logic                penable_i,
  input  logic                pwrite_i,
  input  logic                pready_i,
  input  logic                pslverr_i,
  input  logic [ADDR_W-1:0]   paddr_i,
  input  logic [DATA_W-1:0]   pwdata_i,
  input  logic [DATA_W/8-1:0] pstrb_i,
  input  logic                clr_i,
  output logic [5:0]          err_flags_o,
  output logic                err_pulse_o,
  output logic [CNT_W-1:0]    wr_cnt_o,
  output logic [CNT_W-1:0]    rd_cnt_o,
  output logic [CNT_W-1:0]    err_cnt_o,
  output logic [1:0]          mon_state_o
);

  localparam int unsigned StrbW = DATA_W / 8;
  localparam int unsigned WcntW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StSetup  = 2'd1,
    StAccess = 2'd2
  } phase_e;

  phase_e             phase_q, phase_d;
  logic               pready_q;
  logic [WcntW-1:0]   wcnt_q, wcnt_d;
  logic               to_done_q, to_done_d;
  logic               armed_q, armed_d;
  logic [ADDR_W-1:0]  cap_addr_q, cap_addr_d;
  logic               cap_write_q, cap_write_d;
  logic [DATA_W-1:0]  cap_wdata_q, cap_wdata_d;
  logic [StrbW-1:0]   cap_strb_q, cap_strb_d;
  logic [5:0]         flags_q, flags_d;
  logic               pulse_q, pulse_d;
  logic [CNT_W-1:0]   wr_cnt_q, wr_cnt_d;
  logic [CNT_W-1:0]   rd_cnt_q, rd_cnt_d;
  logic [CNT_W-1:0]   err_cnt_q, err_cnt_d;

  logic               complete;
  logic               chk;
  logic               addr_hit;
  logic [5:0]         viol;
  logic [5:0]         viol_g;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + CNT_W'(1);
  endfunction

  always_comb begin
    phase_d = StIdle;
    if (pselx_i) phase_d = penable_i ? StAccess : StSetup;
  end

  assign complete = (phase_d == StAccess) && pready_i;
  // Checks come alive on the first IDLE sample after reset, including that sample.
  assign chk      = armed_q || (phase_d == StIdle);

  always_comb begin
    addr_hit = 1'b0;
    for (int unsigned k = 0; k < NUM_REGS; k++) begin
      if (paddr_i == ADDR_W'(BASE_ADDR + k * REG_STRIDE)) addr_hit = 1'b1;
    end
  end

  always_comb begin
    viol = '0;
    if (phase_d == StAccess) begin
      viol[0] = !((phase_q == StSetup) || ((phase_q == StAccess) && !pready_q));
      viol[1] = {cap_addr_q, cap_write_q, cap_wdata_q, cap_strb_q} !=
                {paddr_i, pwrite_i, pwdata_i, pstrb_i};
      viol[2] = !pready_i && (wcnt_q == WcntW'(TIMEOUT)) && !to_done_q;
      viol[4] = pready_i && !addr_hit && !pslverr_i;
      viol[5] = pready_i && !pwrite_i && (pstrb_i != '0);
    end else begin
      viol[0] = (phase_q == StSetup);
      viol[3] = (phase_q == StAccess) && !pready_q;
    end
  end

  assign viol_g = chk ? viol : '0;

  always_comb begin
    wcnt_d      = wcnt_q;
    to_done_d   = to_done_q;
    cap_addr_d  = cap_addr_q;
    cap_write_d = cap_write_q;
    cap_wdata_d = cap_wdata_q;
    cap_strb_d  = cap_strb_q;
    if (phase_d == StSetup) begin
      cap_addr_d  = paddr_i;
      cap_write_d = pwrite_i;
      cap_wdata_d = pwdata_i;
      cap_strb_d  = pstrb_i;
    end
    if ((phase_d == StSetup) || complete) begin
      wcnt_d    = '0;
      to_done_d = 1'b0;
    end else if (phase_d == StAccess) begin
      // Counter parks at TIMEOUT so the flag can only fire once per transfer.
      if (wcnt_q != WcntW'(TIMEOUT)) wcnt_d = wcnt_q + WcntW'(1);
      else                           to_done_d = 1'b1;
    end
  end

  always_comb begin
    flags_d   = (clr_i ? 6'b0 : flags_q) | viol_g;
    pulse_d   = |viol_g;
    wr_cnt_d  = clr_i ? '0 : wr_cnt_q;
    rd_cnt_d  = clr_i ? '0 : rd_cnt_q;
    err_cnt_d = clr_i ? '0 : err_cnt_q;
    if (chk && complete && pwrite_i)  wr_cnt_d = sat_inc(wr_cnt_d);
    if (chk && complete && !pwrite_i) rd_cnt_d = sat_inc(rd_cnt_d);
    if (|viol_g)                      err_cnt_d = sat_inc(err_cnt_d);
    armed_d = chk;
  end

  always_ff @(posedge pclk_i or posedge preset_i) begin
    if (preset_i) begin
      phase_q     <= StIdle;
      pready_q    <= 1'b0;
      wcnt_q      <= '0;
      to_done_q   <= 1'b0;
      armed_q     <= 1'b0;
      cap_addr_q  <= '0;
      cap_write_q <= 1'b0;
      cap_wdata_q <= '0;
      cap_strb_q  <= '0;
      flags_q     <= '0;
      pulse_q     <= 1'b0;
      wr_cnt_q    <= '0;
      rd_cnt_q    <= '0;
      err_cnt_q   <= '0;
    end else begin
      phase_q     <= phase_d;
      pready_q    <= pready_i;
      wcnt_q      <= wcnt_d;
      to_done_q   <= to_done_d;
      armed_q     <= armed_d;
      cap_addr_q  <= cap_addr_d;
      cap_write_q <= cap_write_d;
      cap_wdata_q <= cap_wdata_d;
      cap_strb_q  <= cap_strb_d;
      flags_q     <= flags_d;
      pulse_q     <= pulse_d;
      wr_cnt_q    <= wr_cnt_d;
      rd_cnt_q    <= rd_cnt_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign err_flags_o = flags_q;
  assign err_pulse_o = pulse_q;
  assign wr_cnt_o    = wr_cnt_q;
  assign rd_cnt_o    = rd_cnt_q;
  assign err_cnt_o   = err_cnt_q;
  assign mon_state_o = phase_q;

endmodule

// File: tb/tb_apb_protocol_monitor.sv
// Directed table-driven bench for apb_protocol_monitor, plus hand sequences for
// counter saturation and reset during a transfer.
module tb_apb_protocol_monitor;

  logic        pclk = 1'b0;
  logic        preset;
  logic        psel, pen, pwr, prdy, pserr, clr;
  logic [15:0] paddr;
  logic [3:0]  pstrb;
  logic [31:0] pwdata;

  logic [5:0]  flags, flags2;
  logic        pulse, pulse2;
  logic [7:0]  wrc, rdc, errc;
  logic [1:0]  wrc2, rdc2, errc2;
  logic [1:0]  st, st2;

  int checks = 0;
  int passes = 0;

  always #5 pclk = ~pclk;

  apb_protocol_monitor dut (
    .pclk_i(pclk), .preset_i(preset), .pselx_i(psel), .penable_i(pen), .pwrite_i(pwr),
    .pready_i(prdy), .pslverr_i(pserr), .paddr_i(paddr), .pwdata_i(pwdata), .pstrb_i(pstrb),
    .clr_i(clr), .err_flags_o(flags), .err_pulse_o(pulse), .wr_cnt_o(wrc), .rd_cnt_o(rdc),
    .err_cnt_o(errc), .mon_state_o(st)
  );

  apb_protocol_monitor #(.CNT_W(2)) dut2 (
    .pclk_i(pclk), .preset_i(preset), .pselx_i(psel), .penable_i(pen), .pwrite_i(pwr),
    .pready_i(prdy), .pslverr_i(pserr), .paddr_i(paddr), .pwdata_i(pwdata), .pstrb_i(pstrb),
    .clr_i(clr), .err_flags_o(flags2), .err_pulse_o(pulse2), .wr_cnt_o(wrc2), .rd_cnt_o(rdc2),
    .err_cnt_o(errc2), .mon_state_o(st2)
  );

  typedef struct {
    logic        sel, en, wr, rdy, serr, clr;
    logic [15:0] addr;
    logic [3:0]  strb;
    logic [31:0] wd;
    logic [5:0]  flags;
    logic        pulse;
    logic [7:0]  wrc, rdc, errc;
    logic [1:0]  st;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic sel, logic en, logic wr, logic rdy, logic serr, logic c,
                              logic [15:0] a, logic [3:0] s, logic [31:0] d,
                              logic [5:0] f, logic p, logic [7:0] w, logic [7:0] r,
                              logic [7:0] e, logic [1:0] t);
    vec_t v;
    v.sel = sel; v.en = en; v.wr = wr; v.rdy = rdy; v.serr = serr; v.clr = c;
    v.addr = a; v.strb = s; v.wd = d;
    v.flags = f; v.pulse = p; v.wrc = w; v.rdc = r; v.errc = e; v.st = t;
    return v;
  endfunction

  task automatic drive(input logic sel, input logic en, input logic wr, input logic rdy,
                       input logic serr, input logic c, input logic [15:0] a,
                       input logic [3:0] s, input logic [31:0] d);
    psel = sel; pen = en; pwr = wr; prdy = rdy; pserr = serr; clr = c;
    paddr = a; pstrb = s; pwdata = d;
  endtask

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got === exp) passes++;
    else $display("FAIL %s: got %h, required %h", name, got, exp);
  endtask

  task automatic check_all(input string name, input logic [5:0] f, input logic p,
                           input logic [7:0] w, input logic [7:0] r, input logic [7:0] e,
                           input logic [1:0] t);
    checks++;
    if ({flags, pulse, wrc, rdc, errc, st} === {f, p, w, r, e, t}) passes++;
    else $display("FAIL %s: got flags=%b pulse=%b wr=%0d rd=%0d err=%0d st=%0d, required flags=%b pulse=%b wr=%0d rd=%0d err=%0d st=%0d",
                  name, flags, pulse, wrc, rdc, errc, st, f, p, w, r, e, t);
  endtask

  task automatic cycle();
    @(posedge pclk);
    #1;
  endtask

  initial begin
    preset = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 16'h0, 4'h0, 32'h0);

    // Columns: sel en wr rdy serr clr addr strb wdata | flags pulse wr rd err state
    // Zero-wait write to 0x40
    tbl.push_back(mk(0,0,0,0,0,0, 16'h0000,4'h0,32'h0,        6'h00,0,0,0,0,0));
    tbl.push_back(mk(1,0,1,0,0,0, 16'h0040,4'hF,32'hDEADBEEF, 6'h00,0,0,0,0,1));
    tbl.push_back(mk(1,1,1,1,0,0, 16'h0040,4'hF,32'hDEADBEEF, 6'h00,0,1,0,0,2));
    tbl.push_back(mk(0,0,0,0,0,0, 16'h0000,4'h0,32'h0,        6'h00,0,1,0,0,0));
    // Read 0x80 with 3 wait states
    tbl.push_back(mk(1,0,0,0,0,0, 16'h0080,4'h0,32'h0,        6'h00,0,1,0,0,1));
    tbl.push_back(mk(1,1,0,0,0,0, 16'h0080,4'h0,32'h0,        6'h00,0,1,0,0,2));
    tbl.push_back(mk(1,1,0,0,0,0, 16'h0080,4'h0,32'h0,        6'h00,0,1,0,0,2));
    tbl.push_back(mk(1,1,0,0,0,0, 16'h0080,4'h0,32'h0,        6'h00,0,1,0,0,2));
    tbl.push_back(mk(1,1,0,1,0,0, 16'h0080,4'h0,32'h0,        6'h00,0,1,1,0,2));
    tbl.push_back(mk(0,0,0,0,0,0, 16'h0000,4'h0,32'h0,        6'h00,0,1,1,0,0));
    // Same read with 4 wait states: timeout once
    tbl.push_back(mk(1,0,0,0,0,0, 16'h0080,4'h0,32'h0,        6'h00,0,1,1,0,1));
    tbl.push_back(mk(1,1,0,0,0,0, 16'h0080,4'h0,32'h0,        6'h00,0,1,1,0,2));
    tbl.push_back(mk(1,1,0,0,0,0, 16'h0080,4'h0,32'h0,        6'h00,0,1,1,0,2));
    tbl.push_back(mk(1,1,0,0,0,0, 16'h0080,4'h0,32'h0,        6'h00,0,1,1,0,2));
    tbl.push_back(mk(1,1,0,0,0,0, 16'h0080,4'h0,32'h0,        6'h04,1,1,1,1,2));
    tbl.push_back(mk(1,1,0,1,0,0, 16'h0080,4'h0,32'h0,        6'h04,0,1,2,1,2));
    tbl.push_back(mk(0,0,0,0,0,0, 16'h0000,4'h0,32'h0,        6'h04,0,1,2,1,0));
    tbl.push_back(mk(0,0,0,0,0,1, 16'h0000,4'h0,32'h0,        6'h00,0,0,0,0,0));
    // Address changes during a wait state
    tbl.push_back(mk(1,0,1,0,0,0, 16'h0040,4'hF,32'h1234,     6'h00,0,0,0,0,1));
    tbl.push_back(mk(1,1,1,0,0,0, 16'h0040,4'hF,32'h1234,     6'h00,0,0,0,0,2));
    tbl.push_back(mk(1,1,1,0,0,0, 16'h0044,4'hF,32'h1234,     6'h02,1,0,0,1,2));
    tbl.push_back(mk(1,1,1,1,0,0, 16'h0040,4'hF,32'h1234,     6'h02,0,1,0,1,2));
    tbl.push_back(mk(0,0,0,0,0,0, 16'h0000,4'h0,32'h0,        6'h02,0,1,0,1,0));
    // PSELx dropped while waiting
    tbl.push_back(mk(1,0,1,0,0,0, 16'h0040,4'hF,32'h1234,     6'h02,0,1,0,1,1));
    tbl.push_back(mk(1,1,1,0,0,0, 16'h0040,4'hF,32'h1234,     6'h02,0,1,0,1,2));
    tbl.push_back(mk(0,0,0,0,0,0, 16'h0000,4'h0,32'h0,        6'h0A,1,1,0,2,0));
    tbl.push_back(mk(0,0,0,0,0,1, 16'h0000,4'h0,32'h0,        6'h00,0,0,0,0,0));
    // ACCESS straight from IDLE, then a read carrying strobes
    tbl.push_back(mk(1,1,1,1,0,0, 16'h0040,4'hF,32'h1234,     6'h01,1,1,0,1,2));
    tbl.push_back(mk(0,0,0,0,0,0, 16'h0000,4'h0,32'h0,        6'h01,0,1,0,1,0));
    tbl.push_back(mk(1,0,0,0,0,0, 16'h0080,4'h1,32'h0,        6'h01,0,1,0,1,1));
    tbl.push_back(mk(1,1,0,1,0,0, 16'h0080,4'h1,32'h0,        6'h21,1,1,1,2,2));
    tbl.push_back(mk(0,0,0,0,0,0, 16'h0000,4'h0,32'h0,        6'h21,0,1,1,2,0));
    tbl.push_back(mk(0,0,0,0,0,1, 16'h0000,4'h0,32'h0,        6'h00,0,0,0,0,0));
    // Address map: misaligned, misaligned with PSLVERR, beyond map; back-to-back
    tbl.push_back(mk(1,0,1,0,0,0, 16'h0041,4'hF,32'h5,        6'h00,0,0,0,0,1));
    tbl.push_back(mk(1,1,1,1,0,0, 16'h0041,4'hF,32'h5,        6'h10,1,1,0,1,2));
    tbl.push_back(mk(1,0,1,0,0,0, 16'h0041,4'hF,32'h5,        6'h10,0,1,0,1,1));
    tbl.push_back(mk(1,1,1,1,1,0, 16'h0041,4'hF,32'h5,        6'h10,0,2,0,1,2));
    tbl.push_back(mk(1,0,1,0,0,0, 16'h0400,4'hF,32'h5,        6'h10,0,2,0,1,1));
    tbl.push_back(mk(1,1,1,1,0,0, 16'h0400,4'hF,32'h5,        6'h10,1,3,0,2,2));
    tbl.push_back(mk(0,0,0,0,0,0, 16'h0000,4'h0,32'h0,        6'h10,0,3,0,2,0));
    tbl.push_back(mk(0,0,0,0,0,1, 16'h0000,4'h0,32'h0,        6'h00,0,0,0,0,0));
    // SETUP followed by SETUP
    tbl.push_back(mk(1,0,1,0,0,0, 16'h0040,4'hF,32'h7,        6'h00,0,0,0,0,1));
    tbl.push_back(mk(1,0,1,0,0,0, 16'h0040,4'hF,32'h7,        6'h01,1,0,0,1,1));
    tbl.push_back(mk(1,1,1,1,0,0, 16'h0040,4'hF,32'h7,        6'h01,0,1,0,1,2));
    tbl.push_back(mk(0,0,0,0,0,0, 16'h0000,4'h0,32'h0,        6'h01,0,1,0,1,0));
    // clr on the same cycle as an abort
    tbl.push_back(mk(1,0,1,0,0,0, 16'h0040,4'hF,32'h7,        6'h01,0,1,0,1,1));
    tbl.push_back(mk(1,1,1,0,0,0, 16'h0040,4'hF,32'h7,        6'h01,0,1,0,1,2));
    tbl.push_back(mk(0,0,0,0,0,1, 16'h0000,4'h0,32'h0,        6'h08,1,0,0,1,0));

    repeat (2) @(posedge pclk);
    #1;
    check_all("reset", 6'h00, 1'b0, 8'd0, 8'd0, 8'd0, 2'd0);
    @(negedge pclk);
    preset = 1'b0;

    foreach (tbl[i]) begin
      @(negedge pclk);
      drive(tbl[i].sel, tbl[i].en, tbl[i].wr, tbl[i].rdy, tbl[i].serr, tbl[i].clr,
            tbl[i].addr, tbl[i].strb, tbl[i].wd);
      cycle();
      check_all($sformatf("row%0d", i), tbl[i].flags, tbl[i].pulse, tbl[i].wrc, tbl[i].rdc,
                tbl[i].errc, tbl[i].st);
    end

    // Five back-to-back writes: 8-bit counter reaches 5, 2-bit counter saturates at 3
    @(negedge pclk);
    drive(0, 0, 0, 0, 0, 1, 16'h0, 4'h0, 32'h0);
    cycle();
    for (int n = 0; n < 5; n++) begin
      @(negedge pclk);
      drive(1, 0, 1, 0, 0, 0, 16'h0040, 4'hF, 32'h9);
      cycle();
      @(negedge pclk);
      drive(1, 1, 1, 1, 0, 0, 16'h0040, 4'hF, 32'h9);
      cycle();
    end
    @(negedge pclk);
    drive(0, 0, 0, 0, 0, 0, 16'h0, 4'h0, 32'h0);
    cycle();
    check("wr_cnt_w8", 64'(wrc), 64'd5);
    check("wr_cnt_w2_sat", 64'(wrc2), 64'd3);
    check("flags_after_writes", 64'(flags), 64'h0);

    // Reset asserted in the middle of a waited transfer
    @(negedge pclk);
    drive(1, 0, 1, 0, 0, 0, 16'h0040, 4'hF, 32'h9);
    cycle();
    @(negedge pclk);
    drive(1, 1, 1, 0, 0, 0, 16'h0040, 4'hF, 32'h9);
    cycle();
    #2 preset = 1'b1;
    #1;
    check_all("reset_mid_access", 6'h00, 1'b0, 8'd0, 8'd0, 8'd0, 2'd0);
    @(negedge pclk);
    preset = 1'b0;
    drive(1, 1, 1, 1, 0, 0, 16'h0040, 4'hF, 32'h9);
    cycle();
    check_all("access_before_arm", 6'h00, 1'b0, 8'd0, 8'd0, 8'd0, 2'd2);
    @(negedge pclk);
    drive(0, 0, 0, 0, 0, 0, 16'h0, 4'h0, 32'h0);
    cycle();
    @(negedge pclk);
    drive(1, 0, 1, 0, 0, 0, 16'h0080, 4'hF, 32'h3);
    cycle();
    @(negedge pclk);
    drive(1, 1, 1, 1, 0, 0, 16'h0080, 4'hF, 32'h3);
    cycle();
    check_all("write_after_rearm", 6'h00, 1'b0, 8'd1, 8'd0, 8'd0, 2'd2);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
